// File: rtl/logic_gate_pkg.sv
// Shared definitions for the multi-operand gate pipeline: op encoding and widths.
package logic_gate_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } gate_op_t;

endpackage

// File: rtl/logic_gate_pipe_fold.sv
// Combinational N-operand bitwise gate: folds every operand per bit, then applies the selected op.
module gate_fold
  import logic_gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic [OP_W-1:0]         op_i,
  input  logic [NUM_IN*WIDTH-1:0] operands_i,
  output logic [WIDTH-1:0]        result_o
);

  logic [WIDTH-1:0] and_s;
  logic [WIDTH-1:0] or_s;
  logic [WIDTH-1:0] xor_s;
  logic [WIDTH-1:0] op0_s;

  // Full-width fold so NAND/NOR/XNOR invert the N-input reduction, not a 2-input chain.
  always_comb begin
    and_s = '1;
    or_s  = '0;
    xor_s = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      and_s = and_s & operands_i[k*WIDTH +: WIDTH];
      or_s  = or_s  | operands_i[k*WIDTH +: WIDTH];
      xor_s = xor_s ^ operands_i[k*WIDTH +: WIDTH];
    end
  end

  assign op0_s = operands_i[WIDTH-1:0];

  // Final op select; every encoding is legal.
  always_comb begin
    result_o = '0;
    case (gate_op_t'(op_i))
      OP_AND:  result_o = and_s;
      OP_OR:   result_o = or_s;
      OP_XOR:  result_o = xor_s;
      OP_NAND: result_o = ~and_s;
      OP_NOR:  result_o = ~or_s;
      OP_XNOR: result_o = ~xor_s;
      OP_NOT:  result_o = ~op0_s;
      OP_BUF:  result_o = op0_s;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Registered multi-operand gate unit with valid/ready handshake, any-bit flag and transfer counter.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         op,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_any,
  output logic [OP_W-1:0]         out_op,
  output logic [CNT_W-1:0]        xfer_cnt
);

  logic [WIDTH-1:0] fold_s;
  logic             accept_s;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             any_q, any_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  gate_fold #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_fold (
    .op_i       (op),
    .operands_i (in_data),
    .result_o   (fold_s)
  );

  // out_ready passes straight through so a full register refills on the edge it drains.
  assign in_ready = ~rst & (~valid_q | out_ready);
  assign accept_s = in_valid & in_ready;

  // Next-state: accept overrides drain; a drain alone only clears valid.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    any_d   = any_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    if (accept_s) begin
      valid_d = 1'b1;
      data_d  = fold_s;
      any_d   = |fold_s;
      op_d    = op;
      cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      any_q   <= 1'b0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      any_q   <= any_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_any   = any_q;
  assign out_op    = op_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench: two instances (2 operands/16-bit counter, 3 operands/4-bit counter) driven in lockstep.
module tb_logic_gate_pipe;
  import logic_gate_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  op;
  logic [15:0] in_data2;
  logic [23:0] in_data3;
  logic        out_ready;

  logic        in_ready2, out_valid2, out_any2;
  logic [7:0]  out_data2;
  logic [2:0]  out_op2;
  logic [15:0] xfer_cnt2;
  logic        in_ready3, out_valid3, out_any3;
  logic [7:0]  out_data3;
  logic [2:0]  out_op3;
  logic [3:0]  xfer_cnt3;

  int compared = 0;
  int failed   = 0;
  int cnt      = 0;
  int stall_cnt = 0;
  int cyc      = 0;

  logic [11:0] exp2_q[$], exp3_q[$], obs2_q[$], obs3_q[$];

  logic_gate_pipe #(.WIDTH(8), .NUM_IN(2), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .op(op),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_any(out_any2), .out_op(out_op2), .xfer_cnt(xfer_cnt2)
  );

  logic_gate_pipe #(.WIDTH(8), .NUM_IN(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .op(op),
    .in_data(in_data3), .out_valid(out_valid3), .out_ready(out_ready),
    .out_data(out_data3), .out_any(out_any3), .out_op(out_op3), .xfer_cnt(xfer_cnt3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every delivered result, and count cycles a request was refused.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid2 && out_ready) obs2_q.push_back({out_op2, out_any2, out_data2});
      if (out_valid3 && out_ready) obs3_q.push_back({out_op3, out_any3, out_data3});
      if (in_valid && !in_ready2) stall_cnt++;
    end
  end

  // Reference: per bit, count set operands and decide from the count.
  function automatic logic [7:0] model(input logic [2:0] o, input logic [23:0] d, input int n);
    logic [7:0] r;
    int c;
    for (int b = 0; b < 8; b++) begin
      c = 0;
      for (int k = 0; k < n; k++) c += int'(d[k*8+b]);
      case (o)
        3'd0: r[b] = (c == n);
        3'd1: r[b] = (c > 0);
        3'd2: r[b] = (c % 2 == 1);
        3'd3: r[b] = (c != n);
        3'd4: r[b] = (c == 0);
        3'd5: r[b] = (c % 2 == 0);
        3'd6: r[b] = ~d[b];
        default: r[b] = d[b];
      endcase
    end
    return r;
  endfunction

  // Present one request and hold it until both instances accept it (bounded).
  task automatic send(input logic [2:0] o, input logic [23:0] d);
    logic rdy;
    logic [7:0] m2, m3;
    bit done = 1'b0;
    in_valid = 1'b1; op = o; in_data2 = d[15:0]; in_data3 = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready2 && in_ready3;
      @(posedge clk);
      #1;
      done = rdy;
    end
    in_valid = 1'b0;
    if (!done) begin
      compared++; failed++;
      $display("FAIL send_timeout: request op=%0d never accepted", o);
    end else begin
      m2 = model(o, d, 2);
      m3 = model(o, d, 3);
      exp2_q.push_back({o, |m2, m2});
      exp3_q.push_back({o, |m3, m3});
      cnt++;
    end
  endtask

  // Wait until every expected result has been observed (bounded), plus slack for extras.
  task automatic settle();
    for (int i = 0; i < 100 && (obs2_q.size() < exp2_q.size() || obs3_q.size() < exp3_q.size()); i++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    exp2_q.delete(); exp3_q.delete(); obs2_q.delete(); obs3_q.delete();
    cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] m;
    rst = 1'b1; in_valid = 1'b0; op = 3'd0; in_data2 = '0; in_data3 = '0; out_ready = 1'b1;
    #1;
    compared++;
    if (out_valid2 !== 1'b0 || out_data2 !== 8'h00 || out_any2 !== 1'b0 || out_op2 !== 3'd0 ||
        xfer_cnt2 !== 16'd0 || in_ready2 !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: v=%b d=%h any=%b op=%0d cnt=%0d rdy=%b, required 0/00/0/0/0/0",
               out_valid2, out_data2, out_any2, out_op2, xfer_cnt2, in_ready2);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    compared++;
    if (in_ready2 !== 1'b1 || in_ready3 !== 1'b1) begin
      failed++;
      $display("FAIL reset_release_ready: rdy2=%b rdy3=%b, required 1", in_ready2, in_ready3);
    end
    // Mid-stream: leave a result pending, then assert reset asynchronously.
    out_ready = 1'b0;
    send(3'd1, 24'h00_CC_F0);
    compared++;
    if (out_valid2 !== 1'b1 || out_data2 !== 8'hFC) begin
      failed++;
      $display("FAIL reset_pending: v=%b d=%h, required 1/fc", out_valid2, out_data2);
    end
    #2;
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    compared++;
    if (out_valid2 !== 1'b0 || out_data2 !== 8'h00 || xfer_cnt2 !== 16'd0 || in_ready2 !== 1'b0 ||
        out_valid3 !== 1'b0 || xfer_cnt3 !== 4'd0 || in_ready3 !== 1'b0) begin
      failed++;
      $display("FAIL reset_midstream: v=%b d=%h cnt=%0d rdy=%b v3=%b cnt3=%0d rdy3=%b, required all 0",
               out_valid2, out_data2, xfer_cnt2, in_ready2, out_valid3, xfer_cnt3, in_ready3);
    end
    exp2_q.delete(); exp3_q.delete(); obs2_q.delete(); obs3_q.delete();
    cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_all_ops();
    logic [7:0] tbl [8];
    logic [11:0] e, o;
    tbl = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hF0};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 24'hAA_CC_F0);
      compared++;
      if (out_valid2 !== 1'b1 || out_data2 !== tbl[i] || out_any2 !== 1'b1 || out_op2 !== 3'(i)) begin
        failed++;
        $display("FAIL op_%0d: v=%b d=%h any=%b op=%0d, required 1/%h/1/%0d",
                 i, out_valid2, out_data2, out_any2, out_op2, tbl[i], i);
      end
    end
    settle();
    compared++;
    if (obs2_q.size() != exp2_q.size() || obs3_q.size() != exp3_q.size()) begin
      failed++;
      $display("FAIL ops_count: got %0d/%0d results, required %0d/%0d",
               obs2_q.size(), obs3_q.size(), exp2_q.size(), exp3_q.size());
    end
    while (exp2_q.size() > 0 && obs2_q.size() > 0) begin
      e = exp2_q.pop_front(); o = obs2_q.pop_front(); compared++;
      if (o !== e) begin failed++; $display("FAIL ops_sb2: got %h, required %h", o, e); end
    end
    while (exp3_q.size() > 0 && obs3_q.size() > 0) begin
      e = exp3_q.pop_front(); o = obs3_q.pop_front(); compared++;
      if (o !== e) begin failed++; $display("FAIL ops_sb3: got %h, required %h", o, e); end
    end
    exp2_q.delete(); exp3_q.delete(); obs2_q.delete(); obs3_q.delete();
  endtask

  task automatic test_three_inputs();
    logic [2:0] ops [3];
    logic [7:0] want [3];
    ops = '{3'd2, 3'd3, 3'd0};
    want = '{8'h69, 8'hFE, 8'h01};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(ops[i], 24'h55_33_0F);
      compared++;
      if (out_data3 !== want[i] || out_any3 !== 1'b1 || out_op3 !== ops[i]) begin
        failed++;
        $display("FAIL n3_op%0d: d=%h any=%b op=%0d, required %h/1/%0d",
                 ops[i], out_data3, out_any3, out_op3, want[i], ops[i]);
      end
    end
    send(3'd0, 24'hFF_FF_00);
    compared++;
    if (out_data3 !== 8'h00 || out_any3 !== 1'b0 || out_valid3 !== 1'b1) begin
      failed++;
      $display("FAIL n3_and_zero: v=%b d=%h any=%b, required 1/00/0", out_valid3, out_data3, out_any3);
    end
    settle();
    exp2_q.delete(); exp3_q.delete(); obs2_q.delete(); obs3_q.delete();
  endtask

  task automatic test_backpressure();
    logic [11:0] e, o;
    logic [7:0] held;
    int base;
    do_reset();
    base = cnt;
    out_ready = 1'b0;
    fork
      begin
        send(3'd0, 24'h00_CC_F0);
        send(3'd1, 24'h00_0F_81);
        send(3'd2, 24'h00_FF_5A);
        send(3'd5, 24'h00_12_34);
      end
      begin
        @(posedge clk); #2;
        held = out_data2;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          compared++;
          if (in_ready2 !== 1'b0 || out_valid2 !== 1'b1 || out_data2 !== held || out_data2 !== 8'hC0) begin
            failed++;
            $display("FAIL bp_stall%0d: rdy=%b v=%b d=%h, required 0/1/c0", i, in_ready2, out_valid2, out_data2);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    settle();
    compared++;
    if (xfer_cnt2 !== 16'd4 || xfer_cnt3 !== 4'd4 || cnt - base != 4) begin
      failed++;
      $display("FAIL bp_xfer_cnt: got %0d/%0d, required 4", xfer_cnt2, xfer_cnt3);
    end
    compared++;
    if (obs2_q.size() != 4 || exp2_q.size() != 4 || obs3_q.size() != 4) begin
      failed++;
      $display("FAIL bp_count: got %0d/%0d results, required 4", obs2_q.size(), obs3_q.size());
    end
    while (exp2_q.size() > 0 && obs2_q.size() > 0) begin
      e = exp2_q.pop_front(); o = obs2_q.pop_front(); compared++;
      if (o !== e) begin failed++; $display("FAIL bp_sb2: got %h, required %h", o, e); end
    end
    while (exp3_q.size() > 0 && obs3_q.size() > 0) begin
      e = exp3_q.pop_front(); o = obs3_q.pop_front(); compared++;
      if (o !== e) begin failed++; $display("FAIL bp_sb3: got %h, required %h", o, e); end
    end
    exp2_q.delete(); exp3_q.delete(); obs2_q.delete(); obs3_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [11:0] e, o;
    int t0, st0;
    out_ready = 1'b1;
    st0 = stall_cnt;
    t0 = cyc;
    for (int i = 0; i < 20; i++)
      send(3'($urandom_range(0, 7)), 24'($urandom));
    compared++;
    if (cyc - t0 != 20 || stall_cnt != st0) begin
      failed++;
      $display("FAIL b2b_rate: %0d cycles, %0d refusals, required 20 cycles, 0 refusals",
               cyc - t0, stall_cnt - st0);
    end
    settle();
    compared++;
    if (obs2_q.size() != 20 || exp2_q.size() != 20 || obs3_q.size() != 20) begin
      failed++;
      $display("FAIL b2b_count: got %0d/%0d results, required 20", obs2_q.size(), obs3_q.size());
    end
    while (exp2_q.size() > 0 && obs2_q.size() > 0) begin
      e = exp2_q.pop_front(); o = obs2_q.pop_front(); compared++;
      if (o !== e) begin failed++; $display("FAIL b2b_sb2: got %h, required %h", o, e); end
    end
    while (exp3_q.size() > 0 && obs3_q.size() > 0) begin
      e = exp3_q.pop_front(); o = obs3_q.pop_front(); compared++;
      if (o !== e) begin failed++; $display("FAIL b2b_sb3: got %h, required %h", o, e); end
    end
    exp2_q.delete(); exp3_q.delete(); obs2_q.delete(); obs3_q.delete();
  endtask

  task automatic test_wrap();
    logic [7:0] held;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(3'd7, 24'(i));
    out_ready = 1'b0;
    held = out_data3;
    compared++;
    if (xfer_cnt3 !== 4'd1 || xfer_cnt2 !== 16'd17 || cnt != 17) begin
      failed++;
      $display("FAIL wrap_cnt: got %0d/%0d, required 1/17", xfer_cnt3, xfer_cnt2);
    end
    in_valid = 1'b1; op = 3'd6; in_data2 = 16'hFFFF; in_data3 = 24'hFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (xfer_cnt3 !== 4'd1 || xfer_cnt2 !== 16'd17 || out_data3 !== held || out_data3 !== 8'h10 ||
        out_op3 !== 3'd7) begin
      failed++;
      $display("FAIL refused_no_change: cnt=%0d/%0d d=%h op=%0d, required 1/17/10/7",
               xfer_cnt3, xfer_cnt2, out_data3, out_op3);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    settle();
    compared++;
    if (obs3_q.size() != 17 || obs2_q.size() != 17) begin
      failed++;
      $display("FAIL wrap_count: got %0d/%0d results, required 17", obs2_q.size(), obs3_q.size());
    end
    exp2_q.delete(); exp3_q.delete(); obs2_q.delete(); obs3_q.delete();
  endtask

  initial begin
    test_reset();
    test_all_ops();
    test_three_inputs();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
